// File: rtl/ofs_fim_flr_pkg.sv
// Shared types for the FLR responder: function id, AXI-S FLR beat, FSM states.
package ofs_fim_flr_pkg;

  localparam int PFN_W = 3;
  localparam int VFN_W = 11;

  typedef struct packed {
    logic             vf_active;
    logic [PFN_W-1:0] pfn;
    logic [VFN_W-1:0] vfn;
  } t_flr_func;

  typedef struct packed {
    logic      tvalid;
    t_flr_func tdata;
  } t_axis_pcie_flr;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } t_flr_state;

  localparam logic [15:0] FLR_TO_CNT_MAX = 16'hFFFF;

  function automatic int flr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flr_req_fifo.sv
// Request queue. The output register always holds the next head, so a pop
// in IDLE sees valid data in the same cycle without a combinational RAM read.
module flr_req_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // Pointer/count update; a write on a full queue is allowed when a pop frees a slot.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    // Bypass the incoming word when it lands exactly at the next head slot.
    dout_d   = (wr_en && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
  end

  // Storage array, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  // Control and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/pcie_flr_responder.sv
// FLR responder: queues FLR requests, holds the function reset, waits for
// quiesce (or times out), then returns the completion in request order.
module pcie_flr_responder
  import ofs_fim_flr_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic           clk,
  input  logic           rst,
  input  t_axis_pcie_flr flr_req,
  output t_axis_pcie_flr flr_rsp,
  output logic           func_rst_valid,
  output t_flr_func      func_rst_id,
  input  logic           quiesce_done,
  output logic           busy,
  output logic           overflow,
  output logic [15:0]    timeout_cnt
);

  localparam int CNT_MAX = flr_max(RST_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

  t_flr_state       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  t_flr_func        cur_q, cur_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             ovf_q, ovf_d;
  logic             frv_q, frv_d;
  t_flr_func        fid_q, fid_d;
  logic             rsp_vld_q, rsp_vld_d;
  t_flr_func        rsp_dat_q, rsp_dat_d;

  logic             fifo_pop, fifo_full, fifo_empty;
  t_flr_func        fifo_dout;
  logic [FCW-1:0]   fifo_count;

  flr_req_fifo #(
    .WIDTH ($bits(t_flr_func)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (flr_req.tvalid),
    .din   (flr_req.tdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign flr_rsp        = {rsp_vld_q, rsp_dat_q};
  assign func_rst_valid = frv_q;
  assign func_rst_id    = fid_q;
  assign overflow       = ovf_q;
  assign timeout_cnt    = to_cnt_q;
  assign busy           = (state_q != IDLE) || (fifo_count != '0);

  // Sequencer; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    to_cnt_d = to_cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          cnt_d    = CNT_W'(RST_CYCLES - 1);
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        // Quiesce wins over expiry in the same cycle.
        if (quiesce_done) begin
          state_d = RESP;
        end else if (cnt_q == '0) begin
          if (to_cnt_q != FLR_TO_CNT_MAX) to_cnt_d = to_cnt_q + 16'd1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frv_d     = (state_d == ASSERT);
    fid_d     = (state_d == ASSERT) ? cur_d : '0;
    rsp_vld_d = (state_d == RESP);
    rsp_dat_d = (state_d == RESP) ? cur_d : '0;
    // A request is lost only when the queue is full and nothing leaves this cycle.
    ovf_d     = ovf_q | (flr_req.tvalid && fifo_full && !fifo_pop);
  end

  // State and output registers; reset aborts any in-flight FLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      to_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      frv_q     <= 1'b0;
      fid_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      to_cnt_q  <= to_cnt_d;
      ovf_q     <= ovf_d;
      frv_q     <= frv_d;
      fid_q     <= fid_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

endmodule

// File: tb/tb_pcie_flr_responder.sv
// Scoreboard bench for pcie_flr_responder with a timestamp-based reference model.
module tb_pcie_flr_responder;
  import ofs_fim_flr_pkg::*;

  localparam int FD = 8;
  localparam int R  = 16;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  t_axis_pcie_flr flr_req = '0;
  t_axis_pcie_flr flr_rsp;
  logic           func_rst_valid;
  t_flr_func      func_rst_id;
  logic           quiesce_done = 1'b0;
  logic           busy, overflow;
  logic [15:0]    timeout_cnt;

  pcie_flr_responder #(.FIFO_DEPTH(FD), .RST_CYCLES(R), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .flr_req(flr_req), .flr_rsp(flr_rsp),
    .func_rst_valid(func_rst_valid), .func_rst_id(func_rst_id),
    .quiesce_done(quiesce_done), .busy(busy), .overflow(overflow),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: pending requests plus timestamps of the job in service.
  typedef struct { t_flr_func d; int cyc; } exp_t;
  t_flr_func   mq[$];
  exp_t        exp_q[$];
  bit          job = 0;
  t_flr_func   cur = '0;
  int          start = 0;
  int          resp_at = -1;
  bit          m_ovf = 0;
  logic [15:0] m_to = '0;
  logic        e_frv = 0, e_busy = 0, e_ovf = 0;
  t_flr_func   e_id = '0;
  logic [15:0] e_to = '0;

  function automatic t_flr_func mk(input bit vf, input int pfn, input int vfn);
    t_flr_func f;
    f.vf_active = vf;
    f.pfn = 3'(pfn);
    f.vfn = 11'(vfn);
    return f;
  endfunction

  function automatic bit job_done();
    return !job || (resp_at >= 0 && cyc > resp_at);
  endfunction

  task automatic mdl_clear();
    mq.delete(); exp_q.delete();
    job = 0; resp_at = -1; m_ovf = 0; m_to = '0;
    e_frv = 0; e_busy = 0; e_ovf = 0; e_to = '0; e_id = '0;
  endtask

  task automatic mdl_step(input bit v, input t_flr_func d, input bit q);
    bit pop;
    exp_t t;
    if (job && job_done()) job = 0;
    e_frv  = job && (cyc >= start + 1) && (cyc <= start + R);
    e_id   = cur;
    e_busy = (mq.size() > 0) || (job && cyc > start);
    e_ovf  = m_ovf;
    e_to   = m_to;
    pop = !job && (mq.size() > 0);
    if (pop) begin
      cur = mq.pop_front(); job = 1; start = cyc; resp_at = -1;
    end
    // Quiesce window is [start+R+1, start+R+TO]; response one cycle after the deciding cycle.
    if (job && resp_at < 0 && cyc >= start + R + 1) begin
      if (q) resp_at = cyc + 1;
      else if (cyc == start + R + TO) begin
        resp_at = cyc + 1;
        if (m_to != 16'hFFFF) m_to = m_to + 16'd1;
      end
      if (resp_at >= 0) begin
        t.d = cur; t.cyc = resp_at;
        exp_q.push_back(t);
      end
    end
    if (v) begin
      if (mq.size() >= FD) m_ovf = 1;
      else mq.push_back(d);
    end
  endtask

  // vm: 0 idle, 1 request, 2 request only on a pop cycle, 3 random request
  // qm: 0 random, 1 low, 2 pulse 3 cycles into WAIT, 3 on the last WAIT cycle
  task automatic tick(input int vm, input t_flr_func d, input int qm);
    bit v, q;
    @(posedge clk); #1;
    case (vm)
      1:       v = 1;
      2:       v = (mq.size() > 0) && job_done();
      3:       v = ($urandom_range(0, 9) == 0);
      default: v = 0;
    endcase
    case (qm)
      0:       q = ($urandom_range(0, 7) == 0);
      2:       q = job && resp_at < 0 && cyc == start + R + 4;
      3:       q = job && resp_at < 0 && cyc == start + R + TO;
      default: q = 0;
    endcase
    flr_req.tvalid = v;
    flr_req.tdata  = d;
    quiesce_done   = q;
    mdl_step(v, d, q);
  endtask

  task automatic drain(input int qm);
    int n = 0;
    while (!(mq.size() == 0 && exp_q.size() == 0 && job_done()) && n < 2000) begin
      tick(0, '0, qm);
      n++;
    end
    if (n >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d exp_left=%0d", cyc, mq.size(), exp_q.size());
    end
    tick(0, '0, qm);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 0;
    flr_req = '0;
    quiesce_done = 0;
    mdl_step(0, '0, 0);
  endtask

  // Monitor: per-cycle output checks and scoreboard pops on completions.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_rsp_valid", 32'(flr_rsp.tvalid), 0);
      chk("rst_rsp_data", 32'(flr_rsp.tdata), 0);
      chk("rst_func_rst_valid", 32'(func_rst_valid), 0);
      chk("rst_func_rst_id", 32'(func_rst_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_timeout_cnt", 32'(timeout_cnt), 0);
    end else begin
      chk("func_rst_valid", 32'(func_rst_valid), 32'(e_frv));
      if (e_frv) chk("func_rst_id", 32'(func_rst_id), 32'(e_id));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("timeout_cnt", 32'(timeout_cnt), 32'(e_to));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++; n_err++;
        $display("FAIL rsp_missing cyc=%0d exp_cyc=%0d exp_data=%0h", cyc, e.cyc, e.d);
      end
      if (flr_rsp.tvalid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected cyc=%0d got=%0h exp=none", cyc, flr_rsp.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(flr_rsp.tdata), 32'(e.d));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_clear();
    repeat (3) @(posedge clk);
    release_rst();

    // single PF FLR with quiesce 3 cycles into WAIT
    tick(1, mk(0, 1, 0), 2);
    drain(2);

    // VF FLR that times out
    tick(1, mk(1, 0, 5), 1);
    drain(1);

    // burst of 8, responses must come back in order
    for (int i = 0; i < 8; i++) tick(1, mk(0, 0, i), 0);
    drain(0);

    // quiesce on the same cycle the wait counter expires
    tick(1, mk(0, 2, 3), 3);
    drain(3);

    // fill the queue, then push only on pop cycles (full + push + pop)
    for (int i = 0; i < 9; i++) tick(1, mk(0, 3, i), 0);
    for (int i = 0; i < 120; i++) tick(2, mk(0, 4, i), 0);
    drain(0);

    // overflow: 10 back-to-back with depth 8
    for (int i = 0; i < 10; i++) tick(1, mk(1, 1, i), 0);
    drain(0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      tick(3, mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 2047)), 0);
    drain(0);

    // reset during ASSERT with 3 entries queued
    for (int i = 0; i < 4; i++) tick(1, mk(0, 5, i), 0);
    tick(0, '0, 1);
    tick(0, '0, 1);
    @(posedge clk); #1;
    rst = 1;
    flr_req = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    release_rst();
    for (int i = 0; i < 80; i++) tick(0, '0, 0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL rsp_left_over got=0 exp=%0d", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
